// File: rtl/engine_match_scheduler_if.sv
// Packet-in, engine-control and match-report signals of the scheduler.
// master is the scheduler side, slave is the packet source / engine array.
interface engine_match_scheduler_if #(
  parameter int NUM_ENGINES = 16,
  parameter int ID_W        = 4
);
  logic                   pkt_valid;
  logic                   pkt_sop;
  logic                   pkt_eop;
  logic                   pkt_ready;
  logic                   eng_sod;
  logic                   eng_en;
  logic                   eng_flush;
  logic [NUM_ENGINES-1:0] eng_match;
  logic                   rpt_valid;
  logic                   rpt_ready;
  logic [ID_W-1:0]        rpt_id;
  logic                   rpt_none;
  logic                   rpt_last;

  modport master (
    input  pkt_valid, pkt_sop, pkt_eop,
    input  eng_match, rpt_ready,
    output pkt_ready, eng_sod, eng_en, eng_flush,
    output rpt_valid, rpt_id, rpt_none, rpt_last
  );

  modport slave (
    output pkt_valid, pkt_sop, pkt_eop,
    output eng_match, rpt_ready,
    input  pkt_ready, eng_sod, eng_en, eng_flush,
    input  rpt_valid, rpt_id, rpt_none, rpt_last
  );
endinterface

// File: rtl/engine_match_scheduler.sv
// Sequences payload bytes into a bank of match engines, flushes them,
// then streams the set match bits out lowest index first.
module engine_match_scheduler #(
  parameter int NUM_ENGINES = 16,
  parameter int ID_W        = 4,
  parameter int DRAIN_CYC   = 2
) (
  input logic                      clk,
  input logic                      rst,
  engine_match_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_ENGINES-1:0] match_q, match_d;
  logic                   first_q, first_d;

  logic                   run_acc;
  logic                   abort;
  logic                   hs;
  logic                   vec_zero;
  logic                   single;
  logic [NUM_ENGINES-1:0] low_oh;
  logic [ID_W-1:0]        low_id;

  logic                   rdy;
  logic                   sod;
  logic                   en;
  logic                   flush;
  logic                   rvalid;
  logic [ID_W-1:0]        rid;
  logic                   rnone;
  logic                   rlast;

  assign run_acc  = (state_q == S_RUN) & bus.pkt_valid;
  // A second sop inside a packet restarts the engines.
  assign abort    = run_acc & bus.pkt_sop & ~first_q;
  assign hs       = rvalid & bus.rpt_ready;
  assign vec_zero = (match_q == '0);
  assign single   = ((match_q & (match_q - NUM_ENGINES'(1))) == '0);
  assign low_oh   = match_q & (~match_q + NUM_ENGINES'(1));

  always_comb begin
    low_id = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (match_q[i]) low_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      match_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    first_d = first_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.pkt_valid & bus.pkt_sop) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_RUN;
        first_d = 1'b1;
      end
      S_RUN: begin
        if (run_acc) begin
          first_d = 1'b0;
          if (abort) begin
            state_d = S_CLEAR;
          end else if (bus.pkt_eop) begin
            state_d = S_DRAIN;
            cnt_d   = 4'(DRAIN_CYC);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          match_d = bus.eng_match;
          state_d = S_REPORT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REPORT: begin
        if (hs) begin
          match_d = match_q & ~low_oh;
          if (rlast) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy    = 1'b0;
    sod    = rst | (state_q == S_CLEAR);
    en     = 1'b0;
    flush  = 1'b0;
    rvalid = 1'b0;
    rid    = '0;
    rnone  = 1'b0;
    rlast  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: rdy = ~bus.pkt_sop;
        S_CLEAR: rdy = 1'b0;
        S_RUN: begin
          rdy = 1'b1;
          en  = bus.pkt_valid & ~abort;
        end
        // Counter at zero is the capture cycle, engines hold.
        S_DRAIN: begin
          en    = (cnt_q != '0);
          flush = (cnt_q != '0);
        end
        S_REPORT: begin
          rvalid = 1'b1;
          rid    = vec_zero ? '0 : low_id;
          rnone  = vec_zero;
          rlast  = vec_zero | single;
        end
        default: rdy = 1'b0;
      endcase
    end
  end

  assign bus.pkt_ready = rdy;
  assign bus.eng_sod   = sod;
  assign bus.eng_en    = en;
  assign bus.eng_flush = flush;
  assign bus.rpt_valid = rvalid;
  assign bus.rpt_id    = rid;
  assign bus.rpt_none  = rnone;
  assign bus.rpt_last  = rlast;

endmodule

// File: tb/tb_engine_match_scheduler.sv
// Directed bench: packets in, expected report beats queued on issue,
// a monitor pops and compares every report handshake.
module tb_engine_match_scheduler;

  localparam int N  = 16;
  localparam int IW = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          none;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  engine_match_scheduler_if #(.NUM_ENGINES(N), .ID_W(IW)) bus ();

  engine_match_scheduler #(
    .NUM_ENGINES(N),
    .ID_W       (IW),
    .DRAIN_CYC  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    sod_n = 0, en_n = 0, fl_n = 0, beats_n = 0;
  int    stall = 0;
  int    wait_cnt = 0;
  logic  have_prev = 1'b0;
  beat_t prev, got, want;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_matches(input logic [N-1:0] m);
    beat_t b;
    if (m == '0) begin
      b.id = '0; b.none = 1'b1; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin
          b.id   = IW'(i);
          b.none = 1'b0;
          b.last = ((m >> (i + 1)) == '0);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Report consumer: optionally holds ready low 'stall' cycles per beat.
  always @(posedge clk) begin
    #1;
    if (!bus.rpt_valid) begin
      bus.rpt_ready = 1'b0;
      wait_cnt      = 0;
    end else if (wait_cnt >= stall) begin
      bus.rpt_ready = 1'b1;
      wait_cnt      = 0;
    end else begin
      bus.rpt_ready = 1'b0;
      wait_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (bus.eng_sod) sod_n++;
      if (bus.eng_en && !bus.eng_flush) en_n++;
      if (bus.eng_flush) fl_n++;
      got = '{id: bus.rpt_id, none: bus.rpt_none, last: bus.rpt_last};
      if (have_prev)
        chk("rpt_hold", 32'({bus.rpt_valid, got}), 32'({1'b1, prev}));
      if (bus.rpt_valid && bus.rpt_ready) begin
        beats_n++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got id %0d none %0b", got.id,
                   got.none);
        end else begin
          want = exp_q.pop_front();
          chk("rpt_beat", 32'(got), 32'(want));
        end
      end
      have_prev = bus.rpt_valid & ~bus.rpt_ready;
      prev      = got;
    end
  end

  task automatic send_byte(input logic s, input logic e);
    bus.pkt_valid = 1'b1;
    bus.pkt_sop   = s;
    bus.pkt_eop   = e;
    for (int b = 0; b <= 50; b++) begin
      @(negedge clk);
      if (bus.pkt_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      if (b == 50) begin
        checks++;
        errors++;
        $display("FAIL pkt_timeout: got ready 0 want 1");
      end
    end
    bus.pkt_valid = 1'b0;
    bus.pkt_sop   = 1'b0;
    bus.pkt_eop   = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [N-1:0] m);
    bus.eng_match = m;
    push_matches(m);
    for (int i = 0; i < n; i++) send_byte(i == 0, i == n - 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rpt_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL report_timeout: got %0d pending want 0", exp_q.size());
  endtask

  initial begin
    int s0, e0, f0, b0;
    rst           = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.pkt_sop   = 1'b0;
    bus.pkt_eop   = 1'b0;
    bus.eng_match = '0;
    bus.rpt_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
    chk("rst_eng_sod", 32'(bus.eng_sod), 32'd1);
    chk("rst_eng_en", 32'(bus.eng_en), 32'd0);
    chk("rst_eng_flush", 32'(bus.eng_flush), 32'd0);
    chk("rst_rpt_valid", 32'(bus.rpt_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_sod", 32'(bus.eng_sod), 32'd0);
    chk("idle_ready", 32'(bus.pkt_ready), 32'd1);

    // 5-byte packet, no match
    s0 = sod_n; e0 = en_n; f0 = fl_n;
    send_pkt(5, 16'h0000);
    wait_done();
    chk("t1_sod", 32'(sod_n - s0), 32'd1);
    chk("t1_en", 32'(en_n - e0), 32'd5);
    chk("t1_flush", 32'(fl_n - f0), 32'd2);

    // multi-bit report, free-flowing then stalled
    send_pkt(4, 16'h8405);
    wait_done();
    stall = 3;
    send_pkt(3, 16'h8405);
    wait_done();
    stall = 0;

    // sop inside packet aborts it
    s0 = sod_n; e0 = en_n;
    bus.eng_match = 16'h0003;
    push_matches(16'h0003);
    send_byte(1'b1, 1'b0);
    send_byte(1'b0, 1'b0);
    send_byte(1'b0, 1'b0);
    send_byte(1'b1, 1'b0);
    send_byte(1'b0, 1'b0);
    send_byte(1'b0, 1'b0);
    send_byte(1'b0, 1'b1);
    wait_done();
    chk("t4_sod", 32'(sod_n - s0), 32'd2);
    chk("t4_en", 32'(en_n - e0), 32'd6);

    // stray bytes in idle, then a one-byte packet
    e0 = en_n; f0 = fl_n; b0 = beats_n;
    send_byte(1'b0, 1'b0);
    send_byte(1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk("t5_stray_en", 32'(en_n - e0), 32'd0);
    chk("t5_stray_rpt", 32'(beats_n - b0), 32'd0);
    send_pkt(1, 16'h0000);
    wait_done();
    chk("t5_one_en", 32'(en_n - e0), 32'd1);
    chk("t5_one_flush", 32'(fl_n - f0), 32'd2);

    // reset mid-report after the first of three beats
    stall = 3;
    b0 = beats_n;
    send_pkt(2, 16'h0111);
    for (int i = 0; i <= 400; i++) begin
      @(negedge clk);
      if (beats_n > b0) break;
      if (i == 400) begin
        checks++;
        errors++;
        $display("FAIL t6_first_beat: got 0 beats want 1");
      end
    end
    @(posedge clk); #2;
    chk("t6_pending", 32'(bus.rpt_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.rpt_valid), 32'd0);
    chk("t6_rst_sod", 32'(bus.eng_sod), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst   = 1'b0;
    stall = 0;
    b0    = beats_n;
    send_pkt(3, 16'h0020);
    wait_done();
    chk("t6_beats", 32'(beats_n - b0), 32'd1);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/engine_match_scheduler.md
ENGINE_MATCH_SCHEDULER -- requirements
Module: engine_match_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENGINES, default 16, the number of payload engines controlled.
REQ-002 SHALL have parameter ID_W, default 4, the width of the reported engine index; the design SHALL require 2**ID_W >= NUM_ENGINES.
REQ-003 SHALL have parameter DRAIN_CYC, default 2, the number of flush cycles after the last payload byte (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-006 SHALL have port pkt_valid, input, 1, payload byte present.
REQ-007 SHALL have port pkt_sop, input, 1, the byte is the first of its packet.
REQ-008 SHALL have port pkt_eop, input, 1, the byte is the last of its packet.
REQ-009 SHALL have port pkt_ready, output, 1, a byte is accepted when pkt_valid and pkt_ready are both high.
REQ-010 SHALL have port eng_sod, output, 1, the clear for all engines, wired to their sod input.
REQ-011 SHALL have port eng_en, output, 1, the clock enable for all engines.
REQ-012 SHALL have port eng_flush, output, 1, forces every character-decode line feeding the engines to 0.
REQ-013 SHALL have port eng_match, input, NUM_ENGINES, the engine out bits; bit i is engine i.
REQ-014 SHALL have ports rpt_valid (output, 1), rpt_ready (input, 1), rpt_id (output, ID_W), rpt_none (output, 1) and rpt_last (output, 1), which together form the match-report stream.

Function
REQ-015 SHALL implement the states IDLE, CLEAR, RUN, DRAIN and REPORT.
REQ-016 IDLE SHALL behave as follows:
- pkt_ready = ~pkt_sop, so stray non-sop bytes are accepted and dropped;
- on pkt_valid & pkt_sop, the next state SHALL be CLEAR, with the sop byte not yet accepted.
REQ-017 CLEAR SHALL last exactly one cycle with eng_sod=1, eng_en=0 and pkt_ready=0, then go to RUN.
REQ-018 RUN SHALL behave as follows:
- pkt_ready=1;
- eng_en = pkt_valid & pkt_ready;
- eng_flush=0.
REQ-019 In RUN, an accepted byte with pkt_eop=1 SHALL cause the next state DRAIN, and the drain counter SHALL load DRAIN_CYC.
REQ-020 In RUN, an accepted byte with pkt_sop=1 (except the first byte of the packet) SHALL abort the packet: that byte is not enabled into the engines, and the next state is CLEAR.
REQ-021 If a byte carries both sop and eop, it SHALL be treated as a one-byte packet.
REQ-022 DRAIN SHALL hold eng_en=1, eng_flush=1 and pkt_ready=0, and decrement the counter each cycle.
REQ-023 When the drain counter reaches 0, the design SHALL capture eng_match into match_vec and go to REPORT.
REQ-024 REPORT with match_vec==0 SHALL present exactly one beat: rpt_valid=1, rpt_none=1, rpt_last=1, rpt_id=0.
REQ-025 REPORT with match_vec!=0 SHALL present the lowest set index as rpt_id with rpt_none=0, and set rpt_last=1 when exactly one bit remains.
REQ-026 On a report handshake (rpt_valid & rpt_ready), the reported bit SHALL be cleared; after the beat with rpt_last, the next state SHALL be IDLE.
REQ-027 Report outputs SHALL be held stable while rpt_valid=1 and rpt_ready=0.
REQ-028 rpt_valid SHALL be 0 outside REPORT, and pkt_ready SHALL be 0 in REPORT.
REQ-029 Indices at or above NUM_ENGINES SHALL never be reported; each set match bit SHALL be reported exactly once per packet, in ascending order.

Reset
REQ-030 While rst=1, the state SHALL be IDLE, match_vec and the drain counter 0, and all outputs 0 except eng_sod.
REQ-031 eng_sod SHALL equal rst OR the CLEAR-state pulse, so the engines are cleared during reset.
REQ-032 Reset asserted in any state, including mid-REPORT, SHALL discard pending reports; after release, the first action SHALL be IDLE awaiting sop.

Verification
REQ-033 Reset, then a 5-byte packet (sop on byte 0, eop on byte 4) with no engine match -> one eng_sod pulse, 5 eng_en cycles, 2 flush cycles, then one beat with rpt_none=1 and rpt_last=1.
REQ-034 A packet after which eng_match=16'h8405 -> rpt_id beats 0, 2, 10, 15 in order, with rpt_last only on 15.
REQ-035 The REQ-034 case with rpt_ready held low for 3 cycles per beat -> rpt_id/rpt_last stable, no beat lost or duplicated.
REQ-036 A new sop at byte 3 of a packet -> eng_sod pulse, the old packet is not reported, and the new packet is reported normally.
REQ-037 Two non-sop bytes in IDLE -> both accepted, eng_en stays 0, no report; a single sop+eop byte -> eng_en high for 1 cycle followed by the drain.
REQ-038 rst pulsed mid-REPORT after 1 of 3 beats -> rpt_valid drops immediately, and the next packet reports only its own matches.
